// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM state encoding, default timing
// parameters and the odd-parity helper. The ACK state only exists when
// PS2_TX_ACK_EN is defined.
package ps2_pkg;

  localparam int unsigned RTS_CYCLES_DEF = 5000;
  localparam int unsigned FILTER_LEN_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
`ifdef PS2_TX_ACK_EN
    , ST_ACK = 3'd5
`endif
  } tx_state_e;

  // Odd parity: returns the bit that makes the total number of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side PS/2 transmitter bundle: command handshake, line samples,
// line drive values/enables and status. slave = transmitter, master = user
// logic plus line pads.
interface ps2_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_out;
  logic       ps2d_out;
  logic       tri_c;
  logic       tri_d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  modport slave (
    input  wr_ps2, din, ps2c_in, ps2d_in,
    output ps2c_out, ps2d_out, tri_c, tri_d, tx_idle, tx_done_tick, ack_err
  );

  modport master (
    output wr_ps2, din, ps2c_in, ps2d_in,
    input  ps2c_out, ps2d_out, tri_c, tri_d, tx_idle, tx_done_tick, ack_err
  );
endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock debounce filter and falling-edge detector, shared by the
// transmitter and receiver. The filtered clock only changes after
// FILTER_LEN identical consecutive samples.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  output logic fall_edge_o
);

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_val_q, f_val_d;

  // Next filter contents and filtered level; level holds while samples disagree.
  always_comb begin
    filter_d = {ps2c_i, filter_q[FILTER_LEN-1:1]};
    if (filter_d == {FILTER_LEN{1'b1}}) begin
      f_val_d = 1'b1;
    end else if (filter_d == {FILTER_LEN{1'b0}}) begin
      f_val_d = 1'b0;
    end else begin
      f_val_d = f_val_q;
    end
  end

  // Filter shift register and filtered clock level.
  always_ff @(posedge clk) begin
    if (reset) begin
      filter_q <= {FILTER_LEN{1'b0}};
      f_val_q  <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_val_q  <= f_val_d;
    end
  end

  assign fall_edge_o = f_val_q & ~f_val_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Holds the clock low for RTS_CYCLES,
// drives the start bit, then shifts out 8 data bits LSB first plus odd
// parity on device clock falling edges and releases data for the stop bit.
// Optional feature macro: PS2_TX_ACK_EN adds the device-acknowledge state
// and a live ack_err; without it ack_err is constant 0.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned RTS_CYCLES = RTS_CYCLES_DEF,
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic     clk,
  input  logic     reset,
  ps2_tx_if.slave  bus
);

  localparam int unsigned TW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

  tx_state_e     state_q;
  logic [8:0]    b_q;
  logic [3:0]    n_q;
  logic [TW-1:0] timer_q;
  logic          tri_c_q;
  logic          tri_d_q;
  logic          ps2d_out_q;
  logic          tx_idle_q;
  logic          done_q;
  logic          fall_edge_s;
`ifdef PS2_TX_ACK_EN
  logic          ack_err_q;
`endif

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .ps2c_i      (bus.ps2c_in),
    .fall_edge_o (fall_edge_s)
  );

  // Transmit FSM; line enables and status are registered alongside the state.
  // tx_idle stays low during the done-tick cycle, which also blocks a request
  // arriving in the cycle the frame finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      b_q        <= 9'd0;
      n_q        <= 4'd0;
      timer_q    <= {TW{1'b0}};
      tri_c_q    <= 1'b0;
      tri_d_q    <= 1'b0;
      ps2d_out_q <= 1'b0;
      tx_idle_q  <= 1'b1;
      done_q     <= 1'b0;
`ifdef PS2_TX_ACK_EN
      ack_err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.wr_ps2 && tx_idle_q) begin
            b_q       <= {odd_parity(bus.din), bus.din};
            timer_q   <= TW'(RTS_CYCLES - 1);
            state_q   <= ST_RTS;
            tri_c_q   <= 1'b1;
            tx_idle_q <= 1'b0;
          end else begin
            tx_idle_q <= 1'b1;
          end
        end
        ST_RTS: begin
          if (timer_q == {TW{1'b0}}) begin
            state_q    <= ST_START;
            tri_c_q    <= 1'b0;
            tri_d_q    <= 1'b1;
            ps2d_out_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_START: begin
          if (fall_edge_s) begin
            n_q        <= 4'd8;
            state_q    <= ST_DATA;
            ps2d_out_q <= b_q[0];
          end
        end
        ST_DATA: begin
          if (fall_edge_s) begin
            b_q <= {1'b0, b_q[8:1]};
            if (n_q == 4'd0) begin
              state_q    <= ST_STOP;
              tri_d_q    <= 1'b0;
              ps2d_out_q <= 1'b0;
            end else begin
              n_q        <= n_q - 4'd1;
              ps2d_out_q <= b_q[1];
            end
          end
        end
        ST_STOP: begin
          if (fall_edge_s) begin
`ifdef PS2_TX_ACK_EN
            state_q <= ST_ACK;
`else
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef PS2_TX_ACK_EN
        ST_ACK: begin
          if (fall_edge_s) begin
            ack_err_q <= bus.ps2d_in;
            state_q   <= ST_IDLE;
            done_q    <= 1'b1;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          tri_c_q    <= 1'b0;
          tri_d_q    <= 1'b0;
          ps2d_out_q <= 1'b0;
          tx_idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ps2c_out     = 1'b0;
  assign bus.ps2d_out     = ps2d_out_q;
  assign bus.tri_c        = tri_c_q;
  assign bus.tri_d        = tri_d_q;
  assign bus.tx_idle      = tx_idle_q;
  assign bus.tx_done_tick = done_q;
`ifdef PS2_TX_ACK_EN
  assign bus.ack_err      = ack_err_q;
`else
  assign bus.ack_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx: each issued command pushes its expected
// 10-bit line image {stop, parity, data} (bit 0 first on the wire) and a
// monitor compares it with the bits the device model captured whenever
// tx_done_tick pulses.
module tb_ps2_tx;

  localparam int RTS  = 40;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset;
  ps2_tx_if bus ();

  ps2_tx #(
    .RTS_CYCLES (RTS),
    .FILTER_LEN (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       line_d;
  logic       dev_ack_low = 1'b0;
  logic [9:0] cap_bits;
  logic [9:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;

  assign line_d      = bus.tri_d ? bus.ps2d_out : 1'b1;
  assign bus.ps2d_in = dev_ack_low ? 1'b0 : line_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare one expected frame per done tick.
  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1) begin
      done_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: got tick expected none (bits %0h)", cap_bits);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (cap_bits !== e) begin
          bad++;
          $display("FAIL frame_bits: got %0h expected %0h", cap_bits, e);
        end
      end
      chk("tick_tx_idle", 32'(bus.tx_idle), 32'h0);
    end
  end

  // Issue a command and check the request-to-send window and start bit.
  task automatic send(input logic [7:0] d, input logic [9:0] e, input bit push);
    int cnt;
    @(posedge clk); #1;
    bus.din    = d;
    bus.wr_ps2 = 1'b1;
    @(posedge clk); #1;
    bus.wr_ps2 = 1'b0;
    if (push) exp_q.push_back(e);
    cnt = 0;
    for (int i = 0; i < RTS + 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_tx_idle", 32'(bus.tx_idle), 32'h0);
      if (bus.tri_c === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    chk("rts_len", 32'(cnt), 32'(RTS));
    chk("start_tri_d", 32'(bus.tri_d), 32'h1);
    chk("start_bit", 32'(bus.ps2d_out), 32'h0);
    chk("ps2c_out", 32'(bus.ps2c_out), 32'h0);
  endtask

  // Device model: clock pulses until done tick; optional mid-frame events.
  task automatic dev_frame(input int wr_at, input int glitch_at, input int reset_at,
                           input logic ack_low);
    int start_cnt;
    bit got;
    start_cnt = done_cnt;
    got = 1'b0;
    cap_bits = 10'h000;
    for (int k = 1; k <= 14; k++) begin
      if (k >= 11) dev_ack_low = ack_low;
      bus.ps2c_in = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 bus.ps2c_in = 1'b1;
      repeat (HALF / 2) @(posedge clk);
      @(negedge clk);
      if (k <= 10) cap_bits[k-1] = line_d;
      @(posedge clk); #1;
      if (k == glitch_at) begin
        bus.ps2c_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.ps2c_in = 1'b1;
      end
      if (k == wr_at) begin
        bus.din    = 8'h00;
        bus.wr_ps2 = 1'b1;
        @(posedge clk); #1;
        bus.wr_ps2 = 1'b0;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_tri_c", 32'(bus.tri_c), 32'h0);
        chk("rst_tri_d", 32'(bus.tri_d), 32'h0);
        chk("rst_tx_idle", 32'(bus.tx_idle), 32'h1);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        chk("rst_no_tick", 32'(done_cnt), 32'(start_cnt));
        dev_ack_low = 1'b0;
        return;
      end
      repeat (HALF / 2) @(posedge clk);
      #1;
      if (done_cnt != start_cnt) begin
        got = 1'b1;
        break;
      end
    end
    dev_ack_low = 1'b0;
    chk("frame_done_once", 32'(done_cnt - start_cnt), 32'h1);
    if (!got) $display("FAIL frame_timeout: no done tick within 14 device clocks");
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after", 32'(bus.tx_idle), 32'h1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_ps2  = 1'b0;
    bus.din     = 8'h00;
    bus.ps2c_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_tri_c", 32'(bus.tri_c), 32'h0);
    chk("reset_tri_d", 32'(bus.tri_d), 32'h0);
    chk("reset_tx_idle", 32'(bus.tx_idle), 32'h1);
    chk("reset_tick", 32'(bus.tx_done_tick), 32'h0);
    chk("reset_ack_err", 32'(bus.ack_err), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // F4: parity 0
    send(8'hF4, 10'h2F4, 1'b1);
    dev_frame(0, 0, 0, 1'b0);
    // ED: bits 1,0,1,1,0,1,1,1 parity 1, plus a 00 request mid-data
    send(8'hED, 10'h3ED, 1'b1);
    dev_frame(4, 0, 0, 1'b0);
    // ED with a short ps2c glitch during data
    send(8'hED, 10'h3ED, 1'b1);
    dev_frame(0, 3, 0, 1'b0);
    // ED aborted by reset during data, then a clean ED frame
    send(8'hED, 10'h3ED, 1'b0);
    dev_frame(0, 0, 3, 1'b0);
    send(8'hED, 10'h3ED, 1'b1);
    dev_frame(0, 0, 0, 1'b0);
    // Extra patterns
    send(8'h55, 10'h355, 1'b1);
    dev_frame(0, 0, 0, 1'b0);
    send(8'h01, 10'h201, 1'b1);
    dev_frame(0, 0, 0, 1'b0);
    send(8'hFF, 10'h3FF, 1'b1);
    dev_frame(0, 0, 0, 1'b0);
`ifdef PS2_TX_ACK_EN
    chk("ack_err_high", 32'(bus.ack_err), 32'h1);
    send(8'hF4, 10'h2F4, 1'b1);
    dev_frame(0, 0, 0, 1'b1);
    chk("ack_err_low", 32'(bus.ack_err), 32'h0);
`else
    chk("ack_err_tied", 32'(bus.ack_err), 32'h0);
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 The block SHALL have parameter RTS_CYCLES, default 5000, giving the number of clk cycles that ps2c is held low for request-to-send (100 us at 50 MHz).
REQ-002 The block SHALL have parameter FILTER_LEN, default 8, giving the number of consecutive equal ps2c samples required to change the filtered clock.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock. All logic runs on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port wr_ps2, input, 1 bit: single-cycle request to transmit din.
REQ-006 The block SHALL have port din, input, 8 bits: command byte to send to the device.
REQ-007 The block SHALL have port ps2c_in, input, 1 bit: sampled PS/2 clock line.
REQ-008 The block SHALL have port ps2d_in, input, 1 bit: sampled PS/2 data line.
REQ-009 The block SHALL have port ps2c_out, output, 1 bit: value driven on the clock line when tri_c=1.
REQ-010 The block SHALL have port ps2d_out, output, 1 bit: value driven on the data line when tri_d=1.
REQ-011 The block SHALL have port tri_c, output, 1 bit: clock-line drive enable (1 = drive, 0 = release).
REQ-012 The block SHALL have port tri_d, output, 1 bit: data-line drive enable.
REQ-013 The block SHALL have port tx_idle, output, 1 bit: high only in the idle state; intended as rx_en for the receiver.
REQ-014 The block SHALL have port tx_done_tick, output, 1 bit: one-cycle pulse when the frame is complete.
REQ-015 The block SHALL have port ack_err, output, 1 bit: registered; set to 1 when the device did not acknowledge the last frame.

Function
REQ-016 The filtered clock SHALL behave as follows: a FILTER_LEN-bit shift register samples ps2c_in; the filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros, and otherwise holds.
REQ-017 fall_edge SHALL be true when the filtered clock is 1 now and 0 next.
REQ-018 The state machine SHALL have states idle, rts, start, data, stop, and ack (ack only with the macro defined).
REQ-019 In idle, a cycle with wr_ps2=1 SHALL load shift reg b = {odd parity of din, din} (9 bits), load the timer with RTS_CYCLES-1, and go to rts.
REQ-020 In rts, the block SHALL drive tri_c=1 and ps2c_out=0, decrement the timer each cycle, and go to start when the timer is 0.
REQ-021 In start, the block SHALL drive tri_d=1 and ps2d_out=0 and release the clock (tri_c=0); on fall_edge it SHALL set bit counter n=8 and go to data.
REQ-022 In data, the block SHALL drive tri_d=1 and ps2d_out=b[0]; on fall_edge it SHALL shift b right, then go to stop if n==0, otherwise decrement n.
REQ-023 Bits SHALL go out LSB first, followed by the parity bit (9 bits in total).
REQ-024 In stop, the block SHALL hold tri_d=0, so the pull-up supplies the stop bit; on fall_edge it SHALL go to ack when the macro is defined, else to idle with tx_done_tick=1 that cycle.
REQ-025 tri_c SHALL be 1 only in rts; tri_d SHALL be 1 only in start and data; ps2c_out SHALL be 0 at all times.
REQ-026 A wr_ps2 pulse arriving outside idle SHALL be ignored; it SHALL not be queued and the frame in progress SHALL not be corrupted.
REQ-027 A wr_ps2 pulse in the same cycle the block returns to idle SHALL be ignored; a new request is accepted only in a cycle where state is idle.
REQ-028 tx_idle SHALL be 0 from the cycle after wr_ps2 is accepted until the cycle after tx_done_tick.
REQ-029 Latency: the first clock-line release SHALL occur exactly RTS_CYCLES cycles after the accept edge; the rest of the frame is paced by device clock edges.

Reset
REQ-030 On reset, the block SHALL set state=idle, b=0, n=0, timer=0, the filter register to 0, the filtered clock to 0, and ack_err=0.
REQ-031 On reset, the outputs SHALL be tri_c=0, tri_d=0, tx_idle=1, tx_done_tick=0.
REQ-032 Reset asserted mid-frame SHALL release both lines on the next clk edge and emit no tx_done_tick.

Configuration
REQ-033 With PS2_TX_ACK_EN defined, the ack state SHALL exist: on fall_edge it samples ps2d_in, ack_err <= ps2d_in (0 = acknowledged), goes to idle, and pulses tx_done_tick.
REQ-034 With PS2_TX_ACK_EN undefined, ack_err SHALL be tied to 0, no ack state SHALL exist, and tx_done_tick SHALL pulse on the stop-bit falling edge.

Structure
REQ-035 Shared package ps2_pkg SHALL hold the state encodings, the default RTS_CYCLES and FILTER_LEN, and the odd-parity helper.
REQ-036 Sub-module ps2_clk_filter SHALL contain the filter and edge detector and output fall_edge; the receiver SHALL reuse it.

Verification
REQ-037 Scenario: wr_ps2 with din=8'hED, device model clocking -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done_tick once, tx_idle back to 1.
REQ-038 Scenario: din=8'hF4 -> parity bit 0; tri_c=1 for exactly RTS_CYCLES cycles, then start bit 0 seen before the first device fall edge.
REQ-039 Scenario: second wr_ps2 (din=8'h00) issued mid-data of the 8'hED frame -> ignored; the 8'hED frame is unchanged and exactly one tx_done_tick occurs.
REQ-040 Scenario: with PS2_TX_ACK_EN, the device holds data high on the 11th fall edge -> ack_err=1; a following frame with ack low -> ack_err=0.
REQ-041 Scenario: reset asserted during the data state -> tri_c=tri_d=0 on the next edge, no tx_done_tick, and a new 8'hED frame afterwards completes normally.
REQ-042 Scenario: a ps2c glitch shorter than FILTER_LEN cycles during data -> no bit shift and frame content intact.
